// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: decoded ALU
// operation codes, FSM state encoding, iteration count and the per-operation
// context that is captured when an operation is accepted.
package muldiv_pkg;

  // Decoded ALU operation field as produced by the control decoder.
  localparam int ALUOP_WIDTH = 4;

  // Only these two codes start work in the multiply/divide unit; signedness
  // (MULT vs MULTU, DIV vs DIVU) arrives separately on is_signed.
  localparam logic [ALUOP_WIDTH-1:0] ALU_MULT = 4'd8;
  localparam logic [ALUOP_WIDTH-1:0] ALU_DIV  = 4'd9;

  // One radix-2 step per iteration, so the iteration count equals the
  // operand width.
  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'b00,
    MD_CALC   = 2'b01,
    MD_FINISH = 2'b10
  } md_state_e;

  // Everything the final sign fix-up needs to know about the operation in
  // flight. Signs are only ever set for signed operations, so the fix-up
  // never has to look at is_signed again.
  typedef struct packed {
    logic is_div;
    logic sign_a;
    logic sign_b;
    logic div_zero;
  } md_ctx_t;

endpackage

// File: rtl/muldiv_step.sv
// Single radix-2 iteration of the multiply/divide datapath, purely
// combinational. The caller holds the running state in registers and feeds
// it back through this block once per clock.
//
// Multiply (shift-add): i_acc is the 2*DATA_W accumulator. The low half
// starts as the multiplier and is consumed one bit per step from the LSB;
// the high half accumulates partial products. i_opd is the multiplicand.
//
// Divide (restoring): i_acc low half starts as the dividend and fills with
// quotient bits from the LSB as dividend bits leave from the MSB; i_rem is
// the partial remainder; i_opd is the divisor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  i_is_div,
  input  logic [2*DATA_W-1:0]   i_acc,
  input  logic [DATA_W-1:0]     i_rem,
  input  logic [DATA_W-1:0]     i_opd,
  output logic [2*DATA_W-1:0]   o_acc,
  output logic [DATA_W-1:0]     o_rem
);

  // Shifted partial remainder is DATA_W+1 bits: the stored remainder is
  // always below the divisor, so twice it plus one bit can exceed DATA_W.
  logic [DATA_W:0]   w_shift;
  logic              w_ge;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W:0]   w_sum;

  // One iteration of either shift-add or restoring shift-subtract.
  always_comb begin
    w_shift = {i_rem, i_acc[DATA_W-1]};
    w_ge    = (w_shift >= {1'b0, i_opd});
    // When the subtraction succeeds the true difference is below the
    // divisor, so modular DATA_W-bit arithmetic yields it exactly.
    w_diff  = w_shift[DATA_W-1:0] - i_opd;
    w_sum   = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + {1'b0, i_opd};

    o_acc = i_acc;
    o_rem = i_rem;

    if (i_is_div) begin
      o_rem = w_ge ? w_diff : w_shift[DATA_W-1:0];
      o_acc = {i_acc[2*DATA_W-1:DATA_W], i_acc[DATA_W-2:0], w_ge};
    end else begin
      // The carry out of the add becomes the new accumulator MSB as the
      // whole accumulator shifts right by one.
      o_acc = i_acc[0] ? {w_sum, i_acc[DATA_W-1:1]}
                       : {1'b0, i_acc[2*DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// An accepted MULT/DIV runs 32 radix-2 steps on operand magnitudes, then a
// finish cycle applies signs and writes HI/LO, pulsing done. busy lets the
// hazard logic stall the pipeline; MTHI/MTLO-style writes land only when
// idle and not starting an operation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  // Must equal DATA_W: one quotient/multiplier bit is processed per step.
  parameter int ITER   = MD_ITER
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ALUOP_WIDTH-1:0] alu_op,
  input  logic                   is_signed,
  input  logic [DATA_W-1:0]      op_a,
  input  logic [DATA_W-1:0]      op_b,
  input  logic                   hi_we,
  input  logic                   lo_we,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_W-1:0]      hi,
  output logic [DATA_W-1:0]      lo
);

  localparam int CNT_W = $clog2(ITER);

  md_state_e             r_state;
  md_state_e             w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  md_ctx_t               r_ctx;
  logic [2*DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_opd;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_done;

  logic                  w_is_md_op;
  logic                  w_is_div_op;
  logic                  w_accept;
  logic                  w_sign_a;
  logic                  w_sign_b;
  logic [DATA_W-1:0]     w_mag_a;
  logic [DATA_W-1:0]     w_mag_b;
  logic [2*DATA_W-1:0]   w_acc_nxt;
  logic [DATA_W-1:0]     w_rem_nxt;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_quo;
  logic [DATA_W-1:0]     w_rem_signed;
  logic [DATA_W-1:0]     w_fin_hi;
  logic [DATA_W-1:0]     w_fin_lo;

  // Start is honoured only from IDLE and only for MULT/DIV; everything else
  // (other ops, or any start while busy) is silently ignored.
  assign w_is_div_op = (alu_op == ALU_DIV);
  assign w_is_md_op  = (alu_op == ALU_MULT) || w_is_div_op;
  assign w_accept    = start && w_is_md_op && (r_state == MD_IDLE);

  // Unsigned operations take raw bits; signed ones work on magnitudes.
  assign w_sign_a = is_signed & op_a[DATA_W-1];
  assign w_sign_b = is_signed & op_b[DATA_W-1];
  assign w_mag_a  = w_sign_a ? -op_a : op_a;
  assign w_mag_b  = w_sign_b ? -op_b : op_b;

  muldiv_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_is_div (r_ctx.is_div),
    .i_acc    (r_acc),
    .i_rem    (r_rem),
    .i_opd    (r_opd),
    .o_acc    (w_acc_nxt),
    .o_rem    (w_rem_nxt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order blocks are evaluated.
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic: IDLE -> CALC on accept, CALC for ITER steps,
  // then a single FINISH cycle back to IDLE.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      MD_IDLE:   if (w_accept) w_next_state = MD_CALC;
      MD_CALC:   if (r_cnt == '0) w_next_state = MD_FINISH;
      MD_FINISH: w_next_state = MD_IDLE;
      default:   w_next_state = MD_IDLE;
    endcase
  end

  // FSM outputs: busy depends on state alone so the hazard unit sees no
  // combinational path from start.
  always_comb begin
    busy = (r_state != MD_IDLE);
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Iteration datapath: capture operands on accept, then one step per CALC
  // cycle while the counter walks down to zero.
  always_ff @(posedge clk) begin
    // NOTE: the working registers are cleared on reset even though every
    // accept overwrites them, so a reset always leaves a known datapath.
    if (rst) begin
      r_cnt <= '0;
      r_ctx <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_opd <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            r_ctx.is_div   <= w_is_div_op;
            r_ctx.sign_a   <= w_sign_a;
            r_ctx.sign_b   <= w_sign_b;
            r_ctx.div_zero <= (op_b == '0);
            r_cnt          <= CNT_W'(ITER - 1);
            r_rem          <= '0;
            if (w_is_div_op) begin
              r_acc <= {{DATA_W{1'b0}}, w_mag_a};
              r_opd <= w_mag_b;
            end else begin
              r_acc <= {{DATA_W{1'b0}}, w_mag_b};
              r_opd <= w_mag_a;
            end
          end
        end
        MD_CALC: begin
          r_acc <= w_acc_nxt;
          r_rem <= w_rem_nxt;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up of the magnitude results. Negation is two's complement at
  // the full width of each quantity. A zero divisor leaves the dividend
  // magnitude in the remainder (restoring never subtracts zero away... it
  // always succeeds, shifting the dividend through), so HI comes out as the
  // original op_a; LO is forced to all ones regardless of signs.
  always_comb begin
    w_prod       = (r_ctx.sign_a ^ r_ctx.sign_b) ? -r_acc : r_acc;
    w_quo        = (r_ctx.sign_a ^ r_ctx.sign_b) ? -r_acc[DATA_W-1:0]
                                                 : r_acc[DATA_W-1:0];
    w_rem_signed = r_ctx.sign_a ? -r_rem : r_rem;

    w_fin_hi = w_prod[2*DATA_W-1:DATA_W];
    w_fin_lo = w_prod[DATA_W-1:0];
    if (r_ctx.is_div) begin
      w_fin_hi = w_rem_signed;
      w_fin_lo = r_ctx.div_zero ? '1 : w_quo;
    end
  end

  // Architectural HI/LO and the done pulse. Results land in FINISH; direct
  // writes land only in IDLE when no operation is being accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == MD_FINISH);
      if (r_state == MD_FINISH) begin
        r_hi <= w_fin_hi;
        r_lo <= w_fin_lo;
      end else if ((r_state == MD_IDLE) && !w_accept) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal results,
// then a long randomized phase. A cycle-level behavioural model (countdown
// plus plain arithmetic) is compared against busy/done/hi/lo every cycle.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [ALUOP_WIDTH-1:0] alu_op;
  logic                   is_signed;
  logic [31:0]            op_a;
  logic [31:0]            op_b;
  logic                   hi_we;
  logic                   lo_we;
  logic [31:0]            wdata;
  logic                   busy;
  logic                   done;
  logic [31:0]            hi;
  logic [31:0]            lo;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Model state: cycles left until the result lands, pending result, regs.
  int          m_left = 0;
  logic [63:0] m_pend = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic        m_done = 1'b0;

  muldiv_unit #(.DATA_W(32), .ITER(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_op    (alu_op),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model_calc(input logic is_div, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!is_div) begin
      if (sgn) res = sa * sb;
      else     res = ua * ub;
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      if (sgn) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
      end
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // Model: a result lands 33 edges after the accepting edge.
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (start && (alu_op == ALU_MULT || alu_op == ALU_DIV)) begin
        m_pend <= model_calc(alu_op == ALU_DIV, is_signed, op_a, op_b);
        m_left <= 33;
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, m_left > 0);
      check("cyc_done", done, m_done);
      check("cyc_hi",   hi,   m_hi);
      check("cyc_lo",   lo,   m_lo);
    end
  end

  task automatic clear_inputs();
    start = 0; alu_op = '0; is_signed = 0; op_a = '0; op_b = '0;
    hi_we = 0; lo_we = 0; wdata = '0;
  endtask

  // Wait (bounded) for done; returns busy cycles seen before it.
  task automatic wait_done(output logic got, output int busy_cycles);
    got = 0;
    busy_cycles = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (busy) busy_cycles++;
      if (done) got = 1;
      else @(negedge clk);
    end
  endtask

  task automatic do_op(input string name, input logic [ALUOP_WIDTH-1:0] op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic got;
    int   bc;
    @(negedge clk);
    start = 1; alu_op = op; is_signed = sgn; op_a = a; op_b = b;
    @(negedge clk);
    start = 0; alu_op = '0;
    wait_done(got, bc);
    check({name, "_done"}, got, 1'b1);
    check({name, "_busy_cycles"}, bc, 33);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    @(negedge clk);
    check({name, "_done_once"}, done, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got;
    int   bc;
    int   seen;

    clear_inputs();
    rst = 1;

    // Pin the reference model against hand-computed results.
    check("pin_mult",  model_calc(0, 1, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    check("pin_multu", model_calc(0, 0, 32'hFFFF_FFFD, 32'd7), 64'h0000_0006_FFFF_FFEB);
    check("pin_div",   model_calc(1, 1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("pin_ovf",   model_calc(1, 1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("pin_dz",    model_calc(1, 0, 32'd5, 32'd0), 64'h0000_0005_FFFF_FFFF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hi",   hi,   32'd0);
    check("reset_lo",   lo,   32'd0);
    rst = 0;

    do_op("multu_ff_2",  ALU_MULT, 0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    do_op("mult_m3_7",   ALU_MULT, 1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("multu_m3_7",  ALU_MULT, 0, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);
    do_op("div_m7_2",    ALU_DIV,  1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_100_7",  ALU_DIV,  0, 32'd100, 32'd7, 32'd2, 32'd14);
    do_op("div_ovf",     ALU_DIV,  1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    do_op("divu_5_0",    ALU_DIV,  0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    do_op("div_m5_0",    ALU_DIV,  1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // Start + direct write while busy are both dropped.
    @(negedge clk);
    start = 1; alu_op = ALU_DIV; is_signed = 1; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 0; alu_op = '0;
    repeat (9) @(negedge clk);
    start = 1; alu_op = ALU_MULT; is_signed = 0; op_a = 32'd9; op_b = 32'd9;
    hi_we = 1; wdata = 32'h1234;
    @(negedge clk);
    clear_inputs();
    check("intf_busy", busy, 1'b1);
    wait_done(got, bc);
    check("intf_done", got, 1'b1);
    check("intf_hi", hi, 32'd1);
    check("intf_lo", lo, 32'd333);

    // Idle direct write of LO.
    @(negedge clk);
    lo_we = 1; wdata = 32'hABCD;
    @(negedge clk);
    clear_inputs();
    check("idle_lo_we_lo",   lo,   32'hABCD);
    check("idle_lo_we_hi",   hi,   32'd1);
    check("idle_lo_we_done", done, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1; alu_op = ALU_MULT; is_signed = 1; op_a = 32'd12345; op_b = 32'd678;
    @(negedge clk);
    clear_inputs();
    repeat (13) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi",   hi,   32'd0);
    check("midrst_lo",   lo,   32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    do_op("multu_6_7", ALU_MULT, 0, 32'd6, 32'd7, 32'd0, 32'd42);

    // Randomized traffic: every input random every cycle, rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       alu_op = ALU_MULT;
        1:       alu_op = ALU_DIV;
        2:       alu_op = ALU_WIDTH_RAND();
        default: alu_op = '0;
      endcase
      is_signed = $urandom_range(0, 1);
      op_a  = pick_operand();
      op_b  = pick_operand();
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
    end
    @(negedge clk);
    clear_inputs();
    rst = 0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [ALUOP_WIDTH-1:0] ALU_WIDTH_RAND();
    logic [ALUOP_WIDTH-1:0] v;
    v = ALUOP_WIDTH'($urandom);
    return v;
  endfunction

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit directly downstream of the control decoder.
- Consumes the decoded alu_op for MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers.
- Sits beside the single-cycle ALU in EX. Exposes busy so the hazard logic can stall the pipeline, and a done pulse when HI/LO are updated.
- Also accepts MTHI/MTLO-style direct writes when idle.

Parameters:
- DATA_W, 32, operand/HI/LO width.
- ITER, 32, iteration count; must equal DATA_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation this cycle
- alu_op  in  `ALUOP_WIDTH  decoded op; only `ALU_MULT and `ALU_DIV start work
- is_signed  in  1  1 = MULT/DIV, 0 = MULTU/DIVU
- op_a  in  DATA_W  multiplicand / dividend (rs)
- op_b  in  DATA_W  multiplier / divisor (rt)
- hi_we  in  1  direct write of HI
- lo_we  in  1  direct write of LO
- wdata  in  DATA_W  data for hi_we/lo_we
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Applies mid-operation too; the in-flight result is discarded and no done pulse is issued.
- States: IDLE, CALC, FINISH. busy = (state != IDLE), combinational from state.
- IDLE: at edge E0 with start=1 and alu_op in {ALU_MULT, ALU_DIV}:
  - latch op, is_signed, sign(a), sign(b);
  - latch magnitudes |a|, |b| (magnitude only if is_signed, else raw bits);
  - counter=ITER-1; go to CALC.
- IDLE: start with any other alu_op is ignored.
- Start while busy is ignored. The hazard unit holds the requester until busy=0.
- CALC: one radix-2 step per edge, E1..E32.
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder magnitudes.
  - counter decrements; at counter==0 go to FINISH.
- FINISH (edge E33):
  - Apply signs. Product is negated if sign(a)^sign(b). Quotient is negated if sign(a)^sign(b). Remainder takes sign(a).
  - Write hi/lo. MULT: hi = upper half, lo = lower half. DIV: lo = quotient, hi = remainder.
  - done=1 for exactly the cycle after E33; state=IDLE, so busy=0 in that same cycle.
  - Total: result visible 33 edges after the start edge; a new start may be accepted at E34.
- Divide by zero (op_b==0), signed or unsigned: lo=all ones, hi=op_a (original bits). Same 33-cycle latency, no exception.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, from normal magnitude arithmetic.
- Direct writes (hi_we/lo_we):
  - Take effect at the edge only in IDLE and when not simultaneously accepting start.
  - If start is accepted at the same edge, the direct write is dropped.
  - Writes while busy are dropped; the hazard unit must stall MTHI/MTLO.
  - hi_we and lo_we together write both registers with wdata.
- hi/lo hold their value at all other times, including throughout CALC.
- Width rules: the multiply accumulator is 2*DATA_W bits; the divide partial remainder is DATA_W+1 bits. Two's-complement negation is performed at full width.

Decomposition:
- Shared defines/package: reuse `ALU_MULT, `ALU_DIV, `ALUOP_WIDTH. Add MD_IDLE/MD_CALC/MD_FINISH state encodings (2 bits) and MD_ITER=32.
- One natural sub-module, muldiv_step: combinational single-iteration datapath (mul add-shift, div subtract-shift) selected by op. The FSM, counter, sign fix-up and HI/LO registers remain in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=2 -> busy high cycles 1-33, done pulses once; hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; unsigned MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5 b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=5, done pulses, no hang.
- Start DIV, then at cycle 10 assert start MULT plus hi_we wdata=0x1234 -> both ignored; DIV result lands at cycle 33 unchanged. In idle, lo_we wdata=0xABCD -> lo=0xABCD next cycle, done stays 0.
- Start MULT, assert rst at cycle 15 -> next cycle busy=0, hi=lo=0, no done pulse. A subsequent MULTU 6*7 -> lo=42, hi=0.
